muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer for the MIPS datapath. Implements MULT/MULTU/DIV/DIVU and produces HI/LO.
- Iterates one bit per cycle. Borrows the shared 32-bit Arith unit for each add/subtract step and does its own shifting in HI/LO registers.
- Sits beside the EX stage; the pipeline stalls on busy.

---
 rtl/muldiv_seq_pkg.sv | 21 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_seq.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer: ALU function
// codes, op encodings and the sequencer state type.
package muldiv_seq_pkg;

    localparam logic [5:0] ALUFUNC_ADD = 6'b000000;
    localparam logic [5:0] ALUFUNC_SUB = 6'b000001;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator; shared between operand magnitude
// extraction and final result sign correction.
module muldiv_negate #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer, one bit per cycle, using the shared Arith unit
// for every add/subtract step. Define MULDIV_EARLY_OUT_EN for multiply early-out.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_func,
    output logic        alu_signed,
    input  logic [31:0] alu_out,
    input  logic        alu_ovf
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t        state;
    logic [1:0]    op_q;
    logic [31:0]   a_q, b_q, mag_q;
    logic [CW-1:0] cnt;

    logic is_div, sign_a, sign_b;
    assign is_div = op_q[1];
    assign sign_a = op_q[0] & a_q[31];
    assign sign_b = op_q[0] & b_q[31];

    // One negator yields |a| in PREP and the corrected product/quotient in FIX;
    // the narrow one yields |b| in PREP and the corrected remainder in FIX.
    logic [63:0] neg64_in, neg64_out;
    logic [31:0] neg32_in, neg32_out;
    logic        neg64_en, neg32_en;
    logic [31:0] abs_a, abs_b;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        neg64_in = {32'b0, a_q};
        neg64_en = sign_a;
        neg32_in = b_q;
        neg32_en = sign_b;
        if (state == S_FIX) begin
            neg64_in = is_div ? {32'b0, lo} : {hi, lo};
            neg64_en = sign_a ^ sign_b;
            neg32_in = hi;
            neg32_en = sign_a;
        end
    end

    muldiv_negate #(.W(64)) u_neg64 (.neg(neg64_en), .din(neg64_in), .dout(neg64_out));
    muldiv_negate #(.W(32)) u_neg32 (.neg(neg32_en), .din(neg32_in), .dout(neg32_out));

    assign abs_a      = neg64_out[31:0];
    assign abs_b      = neg32_out;
    assign alu_signed = 1'b0;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = ALUFUNC_ADD;
        if (state == S_RUN) begin
            if (is_div) begin
                alu_a    = {hi[30:0], lo[31]};
                alu_b    = mag_q;
                alu_func = ALUFUNC_SUB;
            end else if (lo[0]) begin
                alu_a = hi;
                alu_b = mag_q;
            end
        end
    end

    // Datapath step results; the ALU is only consulted when it is actually driven.
    logic [31:0] mul_sum, div_r, div_hi, div_lo;
    logic        mul_c, div_take, mul_last;
    logic [63:0] mul_step, mul_res;

    always_comb begin
        mul_sum  = lo[0] ? alu_out : hi;
        mul_c    = lo[0] & alu_ovf;
        mul_step = {mul_c, mul_sum, lo[31:1]};
        div_r    = {hi[30:0], lo[31]};
        div_take = hi[31] | ~alu_ovf;
        div_hi   = div_take ? alu_out : div_r;
        div_lo   = {lo[30:0], div_take};
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Once no multiplier bits remain, the rest of RUN would only shift; do it at once.
    logic [CW-1:0] rem;
    logic [31:0]   lo_mask;
    always_comb begin
        rem      = LAST - cnt;
        lo_mask  = (32'h1 << rem) - 32'h1;
        mul_last = ((mul_step[31:0] & lo_mask) == '0);
        mul_res  = mul_step >> rem;
    end
`else
    always_comb begin
        mul_last = (cnt == LAST);
        mul_res  = mul_step;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mag_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    cnt   <= '0;
                    hi    <= '0;
                    lo    <= is_div ? abs_a : abs_b;
                    mag_q <= is_div ? abs_b : abs_a;
                    if (is_div && b_q == '0) begin
                        hi    <= a_q;
                        lo    <= '1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!is_div && b_q == '0) begin
                        state <= S_FIX;
                    end
`endif
                    else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        hi <= div_hi;
                        lo <= div_lo;
                        if (cnt == LAST) state <= S_FIX;
                    end else begin
                        {hi, lo} <= mul_res;
                        if (mul_last) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= neg64_out[31:0];
                        hi <= neg32_out;
                    end else begin
                        {hi, lo} <= neg64_out;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a behavioural Arith unit answers the DUT,
// expected HI/LO/latency come from plain 64-bit arithmetic.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [5:0]  alu_func;
    logic        alu_signed, alu_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          subs;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_signed(alu_signed),
        .alu_out(alu_out), .alu_ovf(alu_ovf)
    );

    // Shared Arith unit in unsigned mode: ovf is carry for ADD, borrow for SUB.
    always_comb begin
        if (alu_func == 6'b000001) begin
            alu_out = alu_a - alu_b;
            alu_ovf = (alu_a < alu_b);
        end else begin
            {alu_ovf, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int msb_index(input logic [31:0] v);
        for (int i = 31; i >= 0; i--)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] mb;
        if (o[0]) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = {32'b0, x};
            sy = {32'b0, y};
        end
        e.lat  = 35;
        e.subs = 0;
        if (o[1]) begin
            if (y == 32'b0) begin
                e.hi  = x;
                e.lo  = 32'hFFFFFFFF;
                e.lat = 2;
            end else begin
                q = sx / sy;
                r = sx % sy;
                p = q;
                e.lo = p[31:0];
                p = r;
                e.hi = p[31:0];
                e.subs = 32;
            end
        end else begin
            p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
            mb = (o[0] && y[31]) ? (~y + 32'd1) : y;
`ifdef MULDIV_EARLY_OUT_EN
            e.lat = (mb == 32'b0) ? 3 : 4 + msb_index(mb);
`else
            if (msb_index(mb) > 31) e.lat = 0;
`endif
        end
        return e;
    endfunction

    // mode: 0 plain, 1 re-assert start with other operands in cycles 3..34,
    // 2 start first raised in the previous op's DONE cycle, 3 reset at cycle 10.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
        exp_t e;
        int   cyc, subs, ovl, extra;
        bit   seen;
        extra = (mode == 2) ? 1 : 0;
        e = model(o, x, y);
        e.lat += extra;
        sb.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        cyc = 0; subs = 0; ovl = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mode == 2 && cyc == 1) check("b2b_not_accepted", busy, 1'b0);
            if (cyc == 1 + extra) check("busy_prep", busy, 1'b1);
            start = (cyc < 1 + extra) || (mode == 1 && cyc >= 3 && cyc <= 34);
            if (mode == 1 && start) begin
                op = ~o; a = ~x; b = y + 32'd3;
            end
            if (alu_func == 6'b000001) subs++;
            if (!busy && (alu_a != 0 || alu_b != 0 || alu_func != 0)) ovl++;
            if (mode == 3 && cyc == 10) begin
                reset = 1'b0;
                #1;
                check("rst_busy", busy, 1'b0);
                check("rst_hi", hi, 32'b0);
                check("rst_lo", lo, 32'b0);
                check("rst_alu_a", alu_a, 32'b0);
                void'(sb.pop_front());
                start = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("latency", cyc, e.lat);
                check("busy_at_done", busy, 1'b0);
                check("sub_cycles", subs, e.subs);
            end
        end
        check("done_seen", seen, 1'b1);
        check("alu_idle_quiet", ovl, 0);
        if (mode == 1 && seen) begin
            @(negedge clk);
            check("done_pulse", done, 1'b0);
            check("busy_after", busy, 1'b0);
            check("hi_hold", hi, e.hi);
            check("lo_hold", lo, e.lo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #3;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'b0);
        check("reset_lo", lo, 32'b0);
        check("reset_alu", {alu_a, alu_b}, 64'b0);
        check("reset_func", alu_func, 6'b000000);
        check("alu_signed", alu_signed, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, 2);
        @(negedge clk);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
        @(negedge clk);
        run_op(2'b10, 32'd100, 32'd7, 0);
        @(negedge clk);
        run_op(2'b10, 32'd5, 32'd0, 0);
        @(negedge clk);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
        @(negedge clk);
        run_op(2'b11, 32'h80000000, 32'd0, 0);
        @(negedge clk);
        run_op(2'b00, 32'd9, 32'd3, 0);
        @(negedge clk);
        run_op(2'b01, 32'h80000000, 32'h80000000, 0);
        @(negedge clk);
        run_op(2'b00, 32'd12345, 32'd0, 0);
        @(negedge clk);
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, 0);
        @(negedge clk);
        run_op(2'b10, 32'hDEADBEEF, 32'h00001234, 1);
        @(negedge clk);
        run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 3);
        run_op(2'b01, 32'hFFFF0000, 32'h00010001, 0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] rb;
            @(negedge clk);
            rb = (i % 2 == 0) ? $urandom : ($urandom & 32'h000000FF);
            run_op(2'($urandom_range(0, 3)), $urandom, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
